// File: rtl/alu_decoder_pipe.sv
// Registered MIPS ALU-control decoder with valid/ready handshake, 2-entry skid buffer,
// flush, and a saturating counter of delivered exception-flagged entries.
module alu_decoder_pipe #(
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic [2:0]        br_type,
  output logic              break_o,
  output logic              syscall_o,
  output logic              eret_o,
  output logic              reserve_o,
  output logic [4:0]        exccode,
  output logic [31:0]       pc_out,
  output logic [CNT_W-1:0]  exc_count
);

  // ALU operation codes shared with the EX stage (8-bit encodings).
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_J_OP     = 8'b0100_1111;
  localparam logic [7:0] EXE_JAL_OP   = 8'b0101_0000;
  localparam logic [7:0] EXE_JALR_OP  = 8'b0000_1001;
  localparam logic [7:0] EXE_JR_OP    = 8'b0000_1000;
  localparam logic [7:0] EXE_BEQ_OP   = 8'b0101_0001;
  localparam logic [7:0] EXE_BNE_OP   = 8'b0101_0010;
  localparam logic [7:0] EXE_BLEZ_OP  = 8'b0101_0011;
  localparam logic [7:0] EXE_BGTZ_OP  = 8'b0101_0100;
  localparam logic [7:0] EXE_LB_OP    = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP    = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP   = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP   = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP    = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP    = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP    = 8'b1110_1011;

  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_BP  = 5'h09;
  localparam logic [4:0] EXC_RI  = 5'h0A;

  typedef struct packed {
    logic [CTRL_W-1:0] alu;
    logic [2:0]        br;
    logic              brk;
    logic              sys;
    logic              eret;
    logic              rsv;
    logic [4:0]        exc;
    logic [31:0]       pc;
  } entry_t;

  function automatic logic [CTRL_W-1:0] ctl(input logic [7:0] op);
    return CTRL_W'(op);
  endfunction

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op                = instr[31:26];
  assign rs                = instr[25:21];
  assign rt                = instr[20:16];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[15:6];

  entry_t dec;

  always_comb begin
    dec    = '0;
    dec.pc = pc_in;
    case (op)
      6'h00: begin
        case (funct)
          6'h00: dec.alu = ctl(EXE_SLL_OP);
          6'h02: dec.alu = ctl(EXE_SRL_OP);
          6'h03: dec.alu = ctl(EXE_SRA_OP);
          6'h04: dec.alu = ctl(EXE_SLLV_OP);
          6'h06: dec.alu = ctl(EXE_SRLV_OP);
          6'h07: dec.alu = ctl(EXE_SRAV_OP);
          6'h08: begin dec.alu = ctl(EXE_JR_OP);   dec.br = 3'd5; end
          6'h09: begin dec.alu = ctl(EXE_JALR_OP); dec.br = 3'd5; end
          6'h0C: begin dec.sys = 1'b1; dec.exc = EXC_SYS; end
          6'h0D: begin dec.brk = 1'b1; dec.exc = EXC_BP;  end
          6'h10: dec.alu = ctl(EXE_MFHI_OP);
          6'h11: dec.alu = ctl(EXE_MTHI_OP);
          6'h12: dec.alu = ctl(EXE_MFLO_OP);
          6'h13: dec.alu = ctl(EXE_MTLO_OP);
          6'h18: dec.alu = ctl(EXE_MULT_OP);
          6'h19: dec.alu = ctl(EXE_MULTU_OP);
          6'h1A: dec.alu = ctl(EXE_DIV_OP);
          6'h1B: dec.alu = ctl(EXE_DIVU_OP);
          6'h20: dec.alu = ctl(EXE_ADD_OP);
          6'h21: dec.alu = ctl(EXE_ADDU_OP);
          6'h22: dec.alu = ctl(EXE_SUB_OP);
          6'h23: dec.alu = ctl(EXE_SUBU_OP);
          6'h24: dec.alu = ctl(EXE_AND_OP);
          6'h25: dec.alu = ctl(EXE_OR_OP);
          6'h26: dec.alu = ctl(EXE_XOR_OP);
          6'h27: dec.alu = ctl(EXE_NOR_OP);
          6'h2A: dec.alu = ctl(EXE_SLT_OP);
          6'h2B: dec.alu = ctl(EXE_SLTU_OP);
          default: begin dec.rsv = 1'b1; dec.exc = EXC_RI; end
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00:   dec.br = 3'd1;
          5'h01:   dec.br = 3'd2;
          5'h10:   dec.br = 3'd3;
          5'h11:   dec.br = 3'd4;
          default: begin dec.rsv = 1'b1; dec.exc = EXC_RI; end
        endcase
      end
      6'h10: begin
        // MFC0/MTC0 move data only; the ALU is not involved.
        if (rs == 5'h00 || rs == 5'h04) begin
          dec.alu = '0;
        end else if (rs == 5'h10 && funct == 6'h18) begin
          dec.eret = 1'b1;
        end else begin
          dec.rsv = 1'b1;
          dec.exc = EXC_RI;
        end
      end
      6'h02: begin dec.alu = ctl(EXE_J_OP);    dec.br = 3'd5; end
      6'h03: begin dec.alu = ctl(EXE_JAL_OP);  dec.br = 3'd5; end
      6'h04: begin dec.alu = ctl(EXE_BEQ_OP);  dec.br = 3'd5; end
      6'h05: begin dec.alu = ctl(EXE_BNE_OP);  dec.br = 3'd5; end
      6'h06: begin dec.alu = ctl(EXE_BLEZ_OP); dec.br = 3'd5; end
      6'h07: begin dec.alu = ctl(EXE_BGTZ_OP); dec.br = 3'd5; end
      6'h08: dec.alu = ctl(EXE_ADDI_OP);
      6'h09: dec.alu = ctl(EXE_ADDIU_OP);
      6'h0A: dec.alu = ctl(EXE_SLTI_OP);
      6'h0B: dec.alu = ctl(EXE_SLTIU_OP);
      6'h0C: dec.alu = ctl(EXE_ANDI_OP);
      6'h0D: dec.alu = ctl(EXE_ORI_OP);
      6'h0E: dec.alu = ctl(EXE_XORI_OP);
      6'h0F: dec.alu = ctl(EXE_LUI_OP);
      6'h20: dec.alu = ctl(EXE_LB_OP);
      6'h21: dec.alu = ctl(EXE_LH_OP);
      6'h23: dec.alu = ctl(EXE_LW_OP);
      6'h24: dec.alu = ctl(EXE_LBU_OP);
      6'h25: dec.alu = ctl(EXE_LHU_OP);
      6'h28: dec.alu = ctl(EXE_SB_OP);
      6'h29: dec.alu = ctl(EXE_SH_OP);
      6'h2B: dec.alu = ctl(EXE_SW_OP);
      default: begin dec.rsv = 1'b1; dec.exc = EXC_RI; end
    endcase
  end

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic [CNT_W-1:0] exc_count_q, exc_count_d;
  logic   in_hs;
  logic   out_hs;
  logic   main_exc;

  assign in_ready = !rst && !flush &&
                    ((SKID_EN != 0) ? !skid_valid_q : (!main_valid_q || out_ready));
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = main_valid_q && out_ready;
  assign main_exc = main_q.brk || main_q.sys || main_q.eret || main_q.rsv;

  // The skid entry only fills while main is stalled, so main empty implies skid empty.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_d       = '0;
      skid_d       = '0;
    end else if (SKID_EN != 0) begin
      if (out_hs) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
          skid_d       = '0;
        end else begin
          main_valid_d = in_hs;
          main_d       = in_hs ? dec : '0;
        end
      end else if (in_hs) begin
        if (main_valid_q) begin
          skid_valid_d = 1'b1;
          skid_d       = dec;
        end else begin
          main_valid_d = 1'b1;
          main_d       = dec;
        end
      end
    end else begin
      if (in_hs) begin
        main_valid_d = 1'b1;
        main_d       = dec;
      end else if (out_hs) begin
        main_valid_d = 1'b0;
        main_d       = '0;
      end
    end
  end

  always_comb begin
    exc_count_d = exc_count_q;
    if (out_hs && main_exc && exc_count_q != {CNT_W{1'b1}}) begin
      exc_count_d = exc_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      exc_count_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      exc_count_q  <= exc_count_d;
    end
  end

  entry_t out_entry;

  assign out_entry   = main_valid_q ? main_q : '0;
  assign out_valid   = main_valid_q;
  assign alu_control = out_entry.alu;
  assign br_type     = out_entry.br;
  assign break_o     = out_entry.brk;
  assign syscall_o   = out_entry.sys;
  assign eret_o      = out_entry.eret;
  assign reserve_o   = out_entry.rsv;
  assign exccode     = out_entry.exc;
  assign pc_out      = out_entry.pc;
  assign exc_count   = exc_count_q;

endmodule

// File: tb/tb_alu_decoder_pipe.sv
// Scoreboard bench for alu_decoder_pipe: directed vectors push expected entries,
// a negedge monitor pops and compares on each output handshake.
module tb_alu_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc_in, pc_out;
  logic [7:0]  alu_control;
  logic [2:0]  br_type;
  logic        break_o, syscall_o, eret_o, reserve_o;
  logic [4:0]  exccode;
  logic [15:0] exc_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_instr, s_pc_in, s_pc_out;
  logic [7:0]  s_alu_control;
  logic [2:0]  s_br_type;
  logic        s_break_o, s_syscall_o, s_eret_o, s_reserve_o;
  logic [4:0]  s_exccode;
  logic [1:0]  s_exc_count;

  always #5 clk = ~clk;

  alu_decoder_pipe u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .br_type(br_type),
    .break_o(break_o), .syscall_o(syscall_o), .eret_o(eret_o), .reserve_o(reserve_o),
    .exccode(exccode), .pc_out(pc_out), .exc_count(exc_count)
  );

  alu_decoder_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .instr(s_instr), .pc_in(s_pc_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .alu_control(s_alu_control), .br_type(s_br_type),
    .break_o(s_break_o), .syscall_o(s_syscall_o), .eret_o(s_eret_o), .reserve_o(s_reserve_o),
    .exccode(s_exccode), .pc_out(s_pc_out), .exc_count(s_exc_count)
  );

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_BRK  = 4'b1000;
  localparam logic [3:0] F_SYS  = 4'b0100;
  localparam logic [3:0] F_ERET = 4'b0010;
  localparam logic [3:0] F_RSV  = 4'b0001;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  alu;
    bit          alu_care;
    logic [2:0]  br;
    logic [3:0]  flags;
    logic [4:0]  exc;
    bit          lat_check;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   latMode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] alu, input bit care,
                              input logic [2:0] br, input logic [3:0] flags, input logic [4:0] exc);
    exp_t e;
    e.pc = pc; e.alu = alu; e.alu_care = care; e.br = br;
    e.flags = flags; e.exc = exc; e.lat_check = 1'b0; e.acc_cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Present one instruction until accepted, then push its expected decode.
  task automatic applyStimulus(input logic [31:0] i, input exp_t e);
    bit got = 1'b0;
    instr    = i;
    pc_in    = e.pc;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.lat_check = latMode;
    e.acc_cyc   = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  logic [51:0] cur, held;
  bit          held_valid = 1'b0;
  exp_t        mon_e;

  // Monitor: idle zeroing, hold stability under stall, scoreboard compare on handshake.
  always @(negedge clk) begin
    cur = {alu_control, br_type, break_o, syscall_o, eret_o, reserve_o, exccode, pc_out};
    if (!out_valid) begin
      checkOutput("idle_zero", 64'(cur), 64'd0);
    end else begin
      if (held_valid) checkOutput("hold_stable", 64'(cur), 64'(held));
      if (out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output_pc", 64'(pc_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.alu_care) checkOutput("alu_control", 64'(alu_control), 64'(mon_e.alu));
          checkOutput("br_type", 64'(br_type), 64'(mon_e.br));
          checkOutput("exc_flags", 64'({break_o, syscall_o, eret_o, reserve_o}), 64'(mon_e.flags));
          checkOutput("exccode", 64'(exccode), 64'(mon_e.exc));
          checkOutput("pc_out", 64'(pc_out), 64'(mon_e.pc));
          if (mon_e.lat_check) checkOutput("latency", 64'(cyc - mon_e.acc_cyc), 64'd0);
        end
      end
    end
    held_valid = out_valid && !out_ready;
    held       = cur;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  acc;
    bit  hs;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; instr = 32'h0000_0020; pc_in = 32'h0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_instr = 32'h0000_000C; s_pc_in = 32'h0; s_out_ready = 1'b1;

    // Reset held two cycles with in_valid high.
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_exc_count", 64'(exc_count), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;

    // Saturation on the 2-bit counter instance.
    acc = 0;
    s_in_valid = 1'b1;
    for (int k = 0; k < 20 && acc < 5; k++) begin
      @(negedge clk);
      hs = s_in_ready;
      @(posedge clk); #1;
      if (hs) acc++;
      if (acc == 5) s_in_valid = 1'b0;
    end
    s_in_valid = 1'b0;
    checkOutput("sat_accepted", 64'(acc), 64'd5);
    repeat (3) @(negedge clk);
    checkOutput("sat_exc_count", 64'(s_exc_count), 64'd3);

    // Stream decode, one per cycle, latency checked.
    @(posedge clk); #1;
    latMode = 1'b1;
    applyStimulus(32'h0000_0020, mk(32'h100, 8'h20, 1, 3'd0, F_NONE, 5'h00));
    applyStimulus(32'h0000_000C, mk(32'h104, 8'h00, 0, 3'd0, F_SYS,  5'h08));
    applyStimulus(32'h0000_000D, mk(32'h108, 8'h00, 0, 3'd0, F_BRK,  5'h09));
    applyStimulus(32'h4200_0018, mk(32'h10C, 8'h00, 0, 3'd0, F_ERET, 5'h00));
    applyStimulus(32'h7C00_0000, mk(32'h110, 8'h00, 1, 3'd0, F_RSV,  5'h0A));
    applyStimulus(32'h0405_0000, mk(32'h114, 8'h00, 0, 3'd0, F_RSV,  5'h0A));
    latMode = 1'b0;
    waitDrain();
    @(negedge clk);
    checkOutput("stream_exc_count", 64'(exc_count), 64'd5);

    // Legal REGIMM/COP0, jumps/branches, and an undefined SPECIAL funct.
    @(posedge clk); #1;
    applyStimulus(32'h0411_0000, mk(32'h200, 8'h00, 1, 3'd4, F_NONE, 5'h00));
    applyStimulus(32'h4080_6000, mk(32'h204, 8'h00, 1, 3'd0, F_NONE, 5'h00));
    applyStimulus(32'h0400_0000, mk(32'h208, 8'h00, 1, 3'd1, F_NONE, 5'h00));
    applyStimulus(32'h0000_0008, mk(32'h20C, 8'h08, 1, 3'd5, F_NONE, 5'h00));
    applyStimulus(32'h0800_0000, mk(32'h210, 8'h4F, 1, 3'd5, F_NONE, 5'h00));
    applyStimulus(32'h1000_0000, mk(32'h214, 8'h51, 1, 3'd5, F_NONE, 5'h00));
    applyStimulus(32'h0000_0021, mk(32'h218, 8'h21, 1, 3'd0, F_NONE, 5'h00));
    applyStimulus(32'h0000_0001, mk(32'h21C, 8'h00, 1, 3'd0, F_RSV,  5'h0A));
    waitDrain();
    @(negedge clk);
    checkOutput("legal_exc_count", 64'(exc_count), 64'd6);

    // Back-pressure: out_ready low for 3 cycles while feeding 4.
    @(posedge clk); #1;
    fork
      begin
        applyStimulus(32'h0000_0020, mk(32'h300, 8'h20, 1, 3'd0, F_NONE, 5'h00));
        applyStimulus(32'h0000_0022, mk(32'h304, 8'h22, 1, 3'd0, F_NONE, 5'h00));
        applyStimulus(32'h0000_000D, mk(32'h308, 8'h00, 0, 3'd0, F_BRK,  5'h09));
        applyStimulus(32'h0000_0025, mk(32'h30C, 8'h25, 1, 3'd0, F_NONE, 5'h00));
      end
      begin
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    @(negedge clk);
    checkOutput("bp_exc_count", 64'(exc_count), 64'd7);

    // Flush with both entries full and a pending input.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(32'h0000_000C, mk(32'h400, 8'h00, 0, 3'd0, F_SYS, 5'h08));
    applyStimulus(32'h7C00_0000, mk(32'h404, 8'h00, 1, 3'd0, F_RSV, 5'h0A));
    instr = 32'h0000_0020; pc_in = 32'h408; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_exc_count", 64'(exc_count), 64'd7);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    applyStimulus(32'h0000_0022, mk(32'h40C, 8'h22, 1, 3'd0, F_NONE, 5'h00));
    waitDrain();

    // Flush coinciding with delivery of an exception entry still counts it.
    @(posedge clk); #1;
    applyStimulus(32'h0000_000C, mk(32'h500, 8'h00, 0, 3'd0, F_SYS, 5'h08));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_hs_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_hs_exc_count", 64'(exc_count), 64'd8);
    checkOutput("flush_hs_drain", 64'(sb.size()), 64'd0);

    // Reset mid-operation, asserted together with flush.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(32'h0000_000D, mk(32'h600, 8'h00, 0, 3'd0, F_BRK, 5'h09));
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_exc_count", 64'(exc_count), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h0000_0024, mk(32'h604, 8'h24, 1, 3'd0, F_NONE, 5'h00));
    waitDrain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decoder_pipe.md
Name: alu_decoder_pipe

Overview:
- Registered, parametrised successor to the combinational ALU-control decoder in the ID stage.
- Accepts a raw 32-bit MIPS instruction plus PC over a valid/ready handshake.
- Fully decodes SPECIAL, REGIMM (by rt) and COP0 (by rs/funct), and emits ALU control, branch class, exception flags and the CP0 ExcCode.
- A 2-entry skid buffer decouples ID from EX back-pressure; flush support and a saturating exception counter are included.

Parameters:
- CTRL_W, 8: width of alu_control; EXE_*_OP values from defines.vh are zero-extended/truncated to this width.
- CNT_W, 16: width of exc_count.
- SKID_EN, 1: 1 gives a 2-entry skid buffer (full throughput); 0 gives a single register where in_ready = !out_valid | out_ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush from the exception/branch unit
- in_valid  in  1  instruction valid
- in_ready  out  1  decoder can accept
- instr  in  32  instruction word
- pc_in  in  32  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  EX stage accepts
- alu_control  out  CTRL_W  ALU operation code
- br_type  out  3  0 none, 1 BLTZ, 2 BGEZ, 3 BLTZAL, 4 BGEZAL, 5 other branch/jump
- break_o  out  1  BREAK decoded
- syscall_o  out  1  SYSCALL decoded
- eret_o  out  1  ERET decoded
- reserve_o  out  1  reserved-instruction exception
- exccode  out  5  0x08 Sys, 0x09 Bp, 0x0A RI, 0x00 otherwise
- pc_out  out  32  PC of the output entry
- exc_count  out  CNT_W  saturating count of exception-flagged entries delivered

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: out_valid=0, both buffer entries invalid, exc_count=0, in_ready=0 during the rst cycle. All data outputs are 0 while out_valid=0; they are forced to 0, never X.
- Decode (combinational, captured on input handshake in_valid & in_ready):
  - op=0x00: funct mapping is identical to the existing decoder. Funct 0x0D sets break_o with exccode 0x09. Funct 0x0C sets syscall_o with exccode 0x08. Undefined funct sets reserve_o with exccode 0x0A.
  - op=0x01 (REGIMM): rt 0x00/0x01/0x10/0x11 gives br_type 1/2/3/4 with alu_control=0. Any other rt sets reserve_o.
  - op=0x10 (COP0): rs=0x00 (MFC0) or rs=0x04 (MTC0) gives alu_control=0, no flags. rs=0x10 with funct=0x18 sets eret_o. Any other COP0 encoding sets reserve_o.
  - J/JAL/BEQ/BNE/BGTZ/BLEZ/JR/JALR give br_type=5, with alu_control per defines.
  - Any other undefined op sets reserve_o, alu_control=0, exccode 0x0A.
  - Exception flags are mutually exclusive (one-hot or all zero).
- Latency: 1 cycle from input handshake to out_valid when the buffer is empty.
- Skid buffer (SKID_EN=1):
  - Entries: main and skid. in_ready = !skid_valid (registered).
  - Handshake on input while the output is stalled (out_valid & !out_ready) writes the skid entry.
  - On output handshake, skid moves to main.
  - Simultaneous input and output handshake with skid empty: main is replaced in the same cycle.
  - Order is strictly FIFO. No entry is dropped or duplicated.
  - Sustained throughput is 1 per cycle with out_ready=1.
- Flush:
  - Invalidates both entries at the next edge; out_valid=0 the following cycle.
  - in_ready=0 in the flush cycle, so the input is not accepted.
  - flush together with an output handshake: that entry still counts as delivered.
  - exc_count is not cleared by flush.
- rst mid-operation: all entries are discarded at once and exc_count returns to 0. rst takes priority over flush.
- exc_count:
  - Increments by 1 on each output handshake whose entry has any of break/syscall/eret/reserve set.
  - Saturates at 2^CNT_W-1 with no wrap.
- Holding rule: while out_valid=1 and out_ready=0, all outputs are held stable.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=0 during rst, exc_count=0.
- Stream decode: 0x00000020, 0x0000000C, 0x0000000D, 0x42000018, 0x7C000000, 0x04050000 with out_ready=1.
  - Outputs appear one per cycle after 1-cycle latency.
  - alu_control=EXE_ADD_OP; then syscall_o with exccode 0x08; break_o with 0x09; eret_o with 0x00; reserve_o with 0x0A; reserve_o with 0x0A (invalid REGIMM rt).
  - exc_count=5 at the end.
- REGIMM/COP0 legal: 0x04110000 -> br_type=4, no flags. 0x40806000 (MTC0) -> no flags, alu_control=0.
- Back-pressure: drop out_ready for 3 cycles while feeding 4 instructions.
  - in_ready falls after 2 are buffered and outputs hold stable.
  - On release, all 4 instructions emerge in order with no loss or duplication.
- Flush: assert flush with both entries full and in_valid=1 -> out_valid=0 next cycle, input not accepted, exc_count unchanged.
- Saturation: CNT_W=2, deliver 5 syscalls -> exc_count stays at 3.
